// File: rtl/stack_file_if.sv
// rtl/stack_file_if.sv - writeback-to-stack interface bundle
interface stack_file_if #(
    parameter int DW = 16
);
    logic [7:0]    dsp_n_i;
    logic [7:0]    rsp_n_i;
    logic [DW-1:0] T_i;
    logic [DW-1:0] R_i;
    logic          dsk_wen;
    logic          rsk_wen;
    logic          clr_err;
    logic [DW-1:0] T_o;
    logic [DW-1:0] N_o;
    logic [DW-1:0] R_o;
    logic [7:0]    dsp_o;
    logic [7:0]    rsp_o;
    logic          dsk_ovf;
    logic          dsk_unf;
    logic          rsk_ovf;
    logic          rsk_unf;
    logic          step_err;

    modport master (
        output dsp_n_i, rsp_n_i, T_i, R_i, dsk_wen, rsk_wen, clr_err,
        input  T_o, N_o, R_o, dsp_o, rsp_o,
        input  dsk_ovf, dsk_unf, rsk_ovf, rsk_unf, step_err
    );

    modport slave (
        input  dsp_n_i, rsp_n_i, T_i, R_i, dsk_wen, rsk_wen, clr_err,
        output T_o, N_o, R_o, dsp_o, rsp_o,
        output dsk_ovf, dsk_unf, rsk_ovf, rsk_unf, step_err
    );
endinterface

// File: rtl/stack_file.sv
// rtl/stack_file.sv - data and return stacks with checked pointer commits
module stack_file #(
    parameter int DW     = 16,
    parameter int DDEPTH = 32,
    parameter int RDEPTH = 32
) (
    input logic         clk,
    input logic         rst,
    stack_file_if.slave sif
);
    localparam int         DAW  = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;
    localparam int         RAW  = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam logic [7:0] DMAX = 8'(DDEPTH - 1);
    localparam logic [7:0] RMAX = 8'(RDEPTH - 1);

    logic [DW-1:0] dmem [DDEPTH];
    logic [DW-1:0] rmem [RDEPTH];

    logic [DW-1:0] t_q, r_q;
    logic [7:0]    dsp_q, rsp_q;
    logic          dsk_ovf_q, dsk_unf_q, rsk_ovf_q, rsk_unf_q, step_err_q;

    logic [7:0]     dstep, rstep;
    logic           d_push, d_repl, d_pop, d_ill, d_ovf, d_unf, d_push_ok, d_pop_ok;
    logic           r_push, r_repl, r_pop, r_ill, r_ovf, r_unf, r_push_ok, r_pop_ok;
    logic           r_wr;
    logic [RAW-1:0] r_wr_addr;
    logic [DW-1:0]  r_pop_val;

    // Step decode: the difference between the requested and the current pointer
    always_comb begin
        dstep     = sif.dsp_n_i - dsp_q;
        d_push    = sif.dsk_wen && (dstep == 8'h01);
        d_repl    = sif.dsk_wen && (dstep == 8'h00);
        d_pop     = sif.dsk_wen && (dstep == 8'hFF);
        d_ill     = sif.dsk_wen && !(d_push || d_repl || d_pop);
        d_ovf     = d_push && (dsp_q == DMAX);
        d_unf     = d_pop && (dsp_q == 8'h00);
        d_push_ok = d_push && !d_ovf;
        d_pop_ok  = d_pop && !d_unf;
    end

    always_comb begin
        rstep     = sif.rsp_n_i - rsp_q;
        r_push    = sif.rsk_wen && (rstep == 8'h01);
        r_repl    = sif.rsk_wen && (rstep == 8'h00);
        r_pop     = sif.rsk_wen && (rstep == 8'hFF);
        r_ill     = sif.rsk_wen && !(r_push || r_repl || r_pop);
        r_ovf     = r_push && (rsp_q == RMAX);
        r_unf     = r_pop && (rsp_q == 8'h00);
        r_push_ok = r_push && !r_ovf;
        r_pop_ok  = r_pop && !r_unf;
    end

    // Return-stack memory mirrors R at every nonzero level, so a replace
    // above level 0 must also rewrite the slot R came from.
    always_comb begin
        r_wr      = r_push_ok || (r_repl && (rsp_q != 8'h00));
        r_wr_addr = r_push_ok ? sif.rsp_n_i[RAW-1:0] : rsp_q[RAW-1:0];
        r_pop_val = (sif.rsp_n_i == 8'h00) ? '0 : rmem[sif.rsp_n_i[RAW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q        <= '0;
            r_q        <= '0;
            dsp_q      <= '0;
            rsp_q      <= '0;
            dsk_ovf_q  <= 1'b0;
            dsk_unf_q  <= 1'b0;
            rsk_ovf_q  <= 1'b0;
            rsk_unf_q  <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            if (d_push_ok || d_repl || d_pop_ok)
                t_q <= sif.T_i;
            if (d_push_ok || d_pop_ok)
                dsp_q <= sif.dsp_n_i;
            if (r_push_ok || r_repl)
                r_q <= sif.R_i;
            else if (r_pop_ok)
                r_q <= r_pop_val;
            if (r_push_ok || r_pop_ok)
                rsp_q <= sif.rsp_n_i;
            // A newly detected error outranks a concurrent clear
            dsk_ovf_q  <= d_ovf | (dsk_ovf_q & ~sif.clr_err);
            dsk_unf_q  <= d_unf | (dsk_unf_q & ~sif.clr_err);
            rsk_ovf_q  <= r_ovf | (rsk_ovf_q & ~sif.clr_err);
            rsk_unf_q  <= r_unf | (rsk_unf_q & ~sif.clr_err);
            step_err_q <= d_ill | r_ill | (step_err_q & ~sif.clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && d_push_ok)
            dmem[sif.dsp_n_i[DAW-1:0]] <= t_q;
        if (!rst && r_wr)
            rmem[r_wr_addr] <= sif.R_i;
    end

    assign sif.T_o      = t_q;
    assign sif.N_o      = (dsp_q == 8'h00) ? '0 : dmem[dsp_q[DAW-1:0]];
    assign sif.R_o      = r_q;
    assign sif.dsp_o    = dsp_q;
    assign sif.rsp_o    = rsp_q;
    assign sif.dsk_ovf  = dsk_ovf_q;
    assign sif.dsk_unf  = dsk_unf_q;
    assign sif.rsk_ovf  = rsk_ovf_q;
    assign sif.rsk_unf  = rsk_unf_q;
    assign sif.step_err = step_err_q;
endmodule
